// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S sample transmitter.
package i2s_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} i2s_state_t;

   localparam int unsigned SLOT_W      = 32;
   localparam int unsigned FRAME_BITS  = 2 * SLOT_W;
   localparam int unsigned DATA_OFFSET = 1;

endpackage

// File: rtl/i2s_sample_tx_bclk_divider.sv
// Bit-clock divider: bclk toggles every BCLK_DIV clk while run is high.
module bclk_divider #(
   parameter int unsigned BCLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic bclk,
   output logic fall_tick
);

   localparam int unsigned DW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;

   logic [DW-1:0] div_cnt;
   logic          at_wrap;

   assign at_wrap   = (div_cnt == DW'(BCLK_DIV - 1));
   // Asserted in the cycle before bclk falls so users update on that same edge.
   assign fall_tick = run && at_wrap && bclk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (!run) begin
         div_cnt <= '0;
         bclk    <= 1'b0;
      end else if (at_wrap) begin
         div_cnt <= '0;
         bclk    <= ~bclk;
      end else begin
         div_cnt <= div_cnt + DW'(1);
      end
   end

endmodule

// File: rtl/i2s_sample_tx.sv
// Pulls one sample per I2S slot from the sample FIFO and serializes it MSB first,
// muting and counting an underrun whenever the FIFO sits at its low watermark.
module i2s_sample_tx #(
   parameter int unsigned SAMPLE_W = 24,
   parameter int unsigned SLOT_W   = 32,
   parameter int unsigned BCLK_DIV = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                buf_lw,
   output logic                pop_front,
   output logic                bclk,
   output logic                lrclk,
   output logic                sdata,
   output logic                underrun,
   output logic [15:0]         underrun_cnt,
   input  logic                clear_underrun
);

   import i2s_pkg::*;

   localparam int unsigned FRAME_LEN = 2 * SLOT_W;
   localparam int unsigned CW        = $clog2(FRAME_LEN);

   i2s_state_t          state;
   logic [CW-1:0]       bit_cnt;
   logic [CW-1:0]       next_cnt;
   logic [CW-1:0]       pos_next;
   logic [SAMPLE_W-1:0] shift_reg;
   logic                run;
   logic                fall_tick;
   logic                slot_start;
   logic                stop;
   logic                load;
   logic                in_data;

   assign run = (state != IDLE);

   bclk_divider #(.BCLK_DIV(BCLK_DIV)) u_div (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .bclk      (bclk),
      .fall_tick (fall_tick)
   );

   always_comb begin
      next_cnt   = (bit_cnt == CW'(FRAME_LEN - 1)) ? '0 : bit_cnt + CW'(1);
      pos_next   = (next_cnt >= CW'(SLOT_W)) ? next_cnt - CW'(SLOT_W) : next_cnt;
      in_data    = (pos_next >= CW'(DATA_OFFSET)) && (pos_next < CW'(DATA_OFFSET + SAMPLE_W));
      slot_start = fall_tick && (pos_next == '0);
      // The frame ends only at the 63->0 wrap; a mid-frame enable drop finishes the frame.
      stop       = fall_tick && (next_cnt == '0) && (state == DRAIN) && !enable;
      load       = ((state == IDLE) && enable) || (slot_start && !stop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         lrclk        <= 1'b0;
         sdata        <= 1'b0;
         pop_front    <= 1'b0;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         pop_front <= load && !buf_lw;

         if (clear_underrun) begin
            underrun     <= 1'b0;
            underrun_cnt <= '0;
         end else if (load && buf_lw) begin
            underrun <= 1'b1;
            if (underrun_cnt != 16'hFFFF)
               underrun_cnt <= underrun_cnt + 16'd1;
         end

         case (state)
            IDLE: begin
               bit_cnt <= '0;
               lrclk   <= 1'b0;
               sdata   <= 1'b0;
               if (enable) begin
                  state     <= RUN;
                  shift_reg <= buf_lw ? '0 : sample_in;
               end
            end
            RUN, DRAIN: begin
               if ((state == RUN) && !enable)
                  state <= DRAIN;
               else if ((state == DRAIN) && enable)
                  state <= RUN;

               if (fall_tick) begin
                  bit_cnt <= next_cnt;
                  lrclk   <= (next_cnt >= CW'(SLOT_W));
                  if (stop) begin
                     state <= IDLE;
                     sdata <= 1'b0;
                  end else if (in_data) begin
                     sdata     <= shift_reg[SAMPLE_W-1];
                     shift_reg <= shift_reg << 1;
                  end else begin
                     sdata <= 1'b0;
                     if (load)
                        shift_reg <= buf_lw ? '0 : sample_in;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Randomized scoreboard bench for i2s_sample_tx with BCLK_DIV=2 (slot = 128 clk).
module tb_i2s_sample_tx;

   localparam int unsigned SW   = 24;
   localparam int unsigned SLOT = 32;
   localparam int unsigned DIV  = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [SW-1:0] sample_in;
   logic          buf_lw;
   logic          clear_underrun;
   logic          pop_front;
   logic          bclk;
   logic          lrclk;
   logic          sdata;
   logic          underrun;
   logic [15:0]   underrun_cnt;

   i2s_sample_tx #(.SAMPLE_W(SW), .SLOT_W(SLOT), .BCLK_DIV(DIV)) dut (
      .clk            (clk),
      .reset          (reset),
      .enable         (enable),
      .sample_in      (sample_in),
      .buf_lw         (buf_lw),
      .pop_front      (pop_front),
      .bclk           (bclk),
      .lrclk          (lrclk),
      .sdata          (sdata),
      .underrun       (underrun),
      .underrun_cnt   (underrun_cnt),
      .clear_underrun (clear_underrun)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        lr;
      logic [31:0] word;
   } slot_t;

   slot_t       exp_q[$];
   int          pop_cyc[$];
   int unsigned chk_cnt   = 0;
   int unsigned pass_cnt  = 0;
   int unsigned slot_idx  = 0;
   int unsigned exp_pops  = 0;
   int unsigned pop_seen  = 0;
   logic        exp_ur    = 1'b0;
   logic [15:0] exp_cnt   = '0;
   int unsigned edge_no   = 0;
   int unsigned load_edge = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Monitor: reassembles each slot from codec-side bclk rising edges and scores it.
   initial begin : mon
      logic        prev_b;
      logic        prev_p;
      int unsigned nb;
      int          mcyc;
      logic [31:0] dw;
      logic [31:0] lw_bits;
      slot_t       e;
      prev_b = 1'b0; prev_p = 1'b0; nb = 0; mcyc = 0; dw = '0; lw_bits = '0;
      forever begin
         @(negedge clk);
         mcyc++;
         if (reset) begin
            prev_b = 1'b0; prev_p = 1'b0; nb = 0;
         end else begin
            if (pop_front) begin
               pop_seen++;
               pop_cyc.push_back(mcyc);
               check("pop_nonconsecutive", {31'b0, prev_p}, 32'd0);
            end
            prev_p = pop_front;
            if (bclk && !prev_b) begin
               dw      = {dw[30:0], sdata};
               lw_bits = {lw_bits[30:0], lrclk};
               nb++;
               if (nb == SLOT) begin
                  nb = 0;
                  check("slot_expected", {31'b0, exp_q.size() > 0}, 32'd1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     check("slot_sdata", dw, e.word);
                     check("slot_lrclk", lw_bits, {32{e.lr}});
                  end
               end
            end
            prev_b = bclk;
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         edge_no++;
      end
   endtask

   task automatic until_edge(input int unsigned e);
      if (e > edge_no) tick(e - edge_no);
      #1;
   endtask

   task automatic check_ur();
      check("underrun", {31'b0, underrun}, {31'b0, exp_ur});
      check("underrun_cnt", {16'b0, underrun_cnt}, {16'b0, exp_cnt});
   endtask

   // Reference model for one slot: I2S one-bit delay, sample MSB first, zero pad; muted on low watermark.
   task automatic set_slot(input logic [SW-1:0] s, input logic lw);
      slot_t e;
      logic [31:0] idx;
      idx       = slot_idx;
      sample_in = s;
      buf_lw    = lw;
      e.lr      = idx[0];
      e.word    = lw ? 32'd0 : {1'b0, s, 7'b0};
      exp_q.push_back(e);
      slot_idx++;
      if (lw) begin
         exp_ur = 1'b1;
         if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      end else begin
         exp_pops++;
      end
   endtask

   task automatic start(input logic [SW-1:0] s, input logic lw);
      @(negedge clk);
      slot_idx = 0;
      set_slot(s, lw);
      reset  = 1'b0;
      enable = 1'b1;
      tick(1);
      load_edge = edge_no;
      #1;
      check_ur();
   endtask

   task automatic next_slot(input logic [SW-1:0] s, input logic lw);
      until_edge(load_edge + 64);
      check("pop_count", pop_seen, exp_pops);
      set_slot(s, lw);
      until_edge(load_edge + 128);
      load_edge += 128;
      check_ur();
   endtask

   task automatic check_quiet(input string name);
      check(name, {29'b0, bclk, lrclk, sdata}, 32'd0);
   endtask

   initial begin : stim
      reset = 1'b1; enable = 1'b0; sample_in = '0; buf_lw = 1'b0; clear_underrun = 1'b0;
      #2;
      check("rst_outputs", {27'b0, pop_front, bclk, lrclk, sdata, underrun}, 32'd0);
      check("rst_underrun_cnt", {16'b0, underrun_cnt}, 32'd0);
      tick(2);

      start(24'hA5F00F, 1'b0);
      next_slot(24'h123456, 1'b0);
      next_slot(24'h000001, 1'b0);
      next_slot(24'h800000, 1'b0);
      until_edge(load_edge + 8);
      check("pop_gap", pop_cyc[$] - pop_cyc[$-1], 32'd128);

      next_slot(SW'($urandom), 1'b0);
      next_slot(SW'($urandom), 1'b1);
      until_edge(load_edge + 10);
      clear_underrun = 1'b1;
      tick(1);
      #1;
      clear_underrun = 1'b0;
      exp_ur = 1'b0; exp_cnt = '0;
      check_ur();

      until_edge(load_edge + 30);
      enable = 1'b0;
      until_edge(load_edge + 50);
      enable = 1'b1;
      next_slot(SW'($urandom), 1'($urandom_range(0, 1)));
      next_slot(SW'($urandom), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 8; i++)
         next_slot(SW'($urandom), ($urandom_range(0, 3) == 0));

      next_slot(SW'($urandom), 1'b0);
      next_slot(SW'($urandom), 1'b0);
      until_edge(load_edge + 20);
      reset = 1'b1;
      #1;
      check("midreset_outputs", {27'b0, pop_front, bclk, lrclk, sdata, underrun}, 32'd0);
      check("midreset_cnt", {16'b0, underrun_cnt}, 32'd0);
      exp_q.delete();
      exp_ur = 1'b0; exp_cnt = '0;
      tick(3);
      start(SW'($urandom), 1'b0);
      next_slot(SW'($urandom), 1'b0);

      until_edge(load_edge + 10);
      force dut.underrun_cnt = 16'hFFFC;
      tick(1);
      #1;
      release dut.underrun_cnt;
      exp_cnt = 16'hFFFC;
      for (int i = 0; i < 6; i++)
         next_slot(SW'($urandom), 1'b1);

      next_slot(SW'($urandom), 1'b0);
      until_edge(load_edge + 40);
      enable = 1'b0;
      next_slot(SW'($urandom), 1'b0);
      until_edge(load_edge + 128);
      check_quiet("drain_end_quiet");
      for (int i = 0; i < 4; i++) begin
         tick(10);
         #1;
         check_quiet("idle_quiet");
      end
      check("final_pop_count", pop_seen, exp_pops);
      check("scoreboard_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
